// File: rtl/sprite_line_sched_pkg.sv
// Shared types and constants for the sprite scanline scheduler.
package sprite_pkg;

    localparam int unsigned NUM_SPRITES       = 8;
    localparam int unsigned SPR_HEIGHT        = 16;
    localparam int unsigned SPR_BYTES_PER_ROW = 4;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    // One line-buffer slot: which sprite, its ROM number and the row to fetch
    typedef struct packed {
        logic [2:0] spr_idx;
        logic [5:0] num;
        logic [3:0] rowidx;
    } slot_t;

endpackage

// File: rtl/sprite_line_sched_if.sv
// Sprite ROM read port and line-buffer write port of the scheduler.
interface sprite_line_sched_if;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        lb_we;
    logic [1:0]  lb_slot;
    logic [1:0]  lb_byte;
    logic [2:0]  lb_sprite;
    logic [7:0]  lb_data;

    modport master (
        output rom_addr, lb_we, lb_slot, lb_byte, lb_sprite, lb_data,
        input  rom_data
    );

    modport slave (
        input  rom_addr, lb_we, lb_slot, lb_byte, lb_sprite, lb_data,
        output rom_data
    );
endinterface

// File: rtl/sprite_line_sched_spr_row_hit.sv
// Combinational row test for one sprite: does it cover the row, and which
// of its 16 rows (after vertical flip) must be fetched.
module spr_row_hit
    import sprite_pkg::*;
(
    input  logic [8:0] row_i,
    input  logic [7:0] y_i,
    input  logic       yflip_i,
    input  logic       flip_i,
    output logic       hit_o,
    output logic [3:0] rowidx_o
);

    logic [7:0] d;
    logic       in_range;

    // Row offset wraps mod 256; rows outside 16..271 never show sprites
    always_comb begin
        d        = row_i[7:0] - y_i;
        in_range = (row_i >= 9'd16) && (row_i <= 9'd271);
        hit_o    = in_range && (d < 8'(SPR_HEIGHT));
        rowidx_o = (yflip_i ^ flip_i) ? (4'(SPR_HEIGHT - 1) - d[3:0]) : d[3:0];
    end

endmodule

// File: rtl/sprite_line_sched.sv
// Sprite scanline scheduler: during horizontal blank, scans NUM_SPR sprite
// attribute sets for the next row, keeps the first MAX_PER_LINE hits and
// copies their 4-byte rows from sprite ROM into the line buffer.
// Optional feature: define SPRITE_OVF_FLAG_EN to build the overflow flag.
module sprite_line_sched
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPR      = NUM_SPRITES,
    parameter int unsigned MAX_PER_LINE = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       line_start,
    input  logic [8:0]                 next_row,
    input  logic                       flip_bit,
    input  logic [NUM_SPR-1:0][7:0]    spr_y,
    input  logic [NUM_SPR-1:0][5:0]    spr_num,
    input  logic [NUM_SPR-1:0]         spr_yflip,
    sprite_line_sched_if.master        bus,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 lb_count,
    output logic                       spr_ovf
);

    localparam int unsigned IDXW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

    state_t            state_q, state_d;
    logic [8:0]        row_q, row_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [2:0]        cnt_q, cnt_d;
    slot_t             slots_q [MAX_PER_LINE];
    slot_t             slots_d [MAX_PER_LINE];
    logic [1:0]        fslot_q, fslot_d;
    logic [1:0]        fbyte_q, fbyte_d;
    logic              lb_we_q, lb_we_d;
    logic [1:0]        lb_slot_q, lb_slot_d;
    logic [1:0]        lb_byte_q, lb_byte_d;
    logic [2:0]        lb_spr_q, lb_spr_d;
`ifdef SPRITE_OVF_FLAG_EN
    logic              ovf_q, ovf_d;
`endif

    logic              hit;
    logic [3:0]        rowidx;
    slot_t             cur;

    spr_row_hit u_row_hit (
        .row_i    (row_q),
        .y_i      (spr_y[idx_q]),
        .yflip_i  (spr_yflip[idx_q]),
        .flip_i   (flip_bit),
        .hit_o    (hit),
        .rowidx_o (rowidx)
    );

    // Next-state and datapath updates; line_start overrides every state
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        slots_d   = slots_q;
        fslot_d   = fslot_q;
        fbyte_d   = fbyte_q;
        cur       = slots_q[fslot_q];
        lb_we_d   = 1'b0;
        lb_slot_d = fslot_q;
        lb_byte_d = fbyte_q;
        lb_spr_d  = cur.spr_idx;
`ifdef SPRITE_OVF_FLAG_EN
        ovf_d     = ovf_q;
`endif

        if (line_start) begin
            state_d = EVAL;
            row_d   = next_row;
            idx_d   = '0;
            cnt_d   = '0;
            fslot_d = '0;
            fbyte_d = '0;
`ifdef SPRITE_OVF_FLAG_EN
            ovf_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: ;
                EVAL: begin
                    if (hit) begin
                        if (cnt_q < 3'(MAX_PER_LINE)) begin
                            slots_d[cnt_q[1:0]] = '{spr_idx: 3'(idx_q),
                                                    num:     spr_num[idx_q],
                                                    rowidx:  rowidx};
                            cnt_d = cnt_q + 3'd1;
                        end
`ifdef SPRITE_OVF_FLAG_EN
                        else begin
                            ovf_d = 1'b1;
                        end
`endif
                    end
                    if (idx_q == IDXW'(NUM_SPR - 1)) begin
                        state_d = (cnt_d == 3'd0) ? DONE : FETCH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                FETCH: begin
                    lb_we_d = 1'b1;
                    if (fbyte_q == 2'(SPR_BYTES_PER_ROW - 1)) begin
                        fbyte_d = '0;
                        if ((3'(fslot_q) + 3'd1) == cnt_q) begin
                            state_d = DRAIN;
                        end else begin
                            fslot_d = fslot_q + 2'd1;
                        end
                    end else begin
                        fbyte_d = fbyte_q + 2'd1;
                    end
                end
                DRAIN:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            fslot_q   <= '0;
            fbyte_q   <= '0;
            lb_we_q   <= 1'b0;
            lb_slot_q <= '0;
            lb_byte_q <= '0;
            lb_spr_q  <= '0;
            for (int unsigned i = 0; i < MAX_PER_LINE; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            fslot_q   <= fslot_d;
            fbyte_q   <= fbyte_d;
            lb_we_q   <= lb_we_d;
            lb_slot_q <= lb_slot_d;
            lb_byte_q <= lb_byte_d;
            lb_spr_q  <= lb_spr_d;
            slots_q   <= slots_d;
        end
    end

`ifdef SPRITE_OVF_FLAG_EN
    // Sticky overflow flag, cleared only by line_start or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign spr_ovf = ovf_q;
`else
    assign spr_ovf = 1'b0;
`endif

    // ROM address only driven while fetching; write data is the ROM reply
    always_comb begin
        bus.rom_addr  = (state_q == FETCH) ? {cur.num, cur.rowidx, fbyte_q} : '0;
        bus.lb_we     = lb_we_q;
        bus.lb_slot   = lb_slot_q;
        bus.lb_byte   = lb_byte_q;
        bus.lb_sprite = lb_spr_q;
        bus.lb_data   = lb_we_q ? bus.rom_data : '0;
        busy          = (state_q == EVAL) || (state_q == FETCH) || (state_q == DRAIN);
        done          = (state_q == DONE);
        lb_count      = cnt_q;
    end

endmodule

// File: tb/tb_sprite_line_sched.sv
// Self-checking bench for sprite_line_sched: directed boundary lines plus
// randomized lines compared against a per-line reference schedule.
module tb_sprite_line_sched;

    localparam int NSPR = 8;
    localparam int MAXL = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  line_start;
    logic [8:0]            next_row;
    logic                  flip_bit;
    logic [NSPR-1:0][7:0]  spr_y;
    logic [NSPR-1:0][5:0]  spr_num;
    logic [NSPR-1:0]       spr_yflip;
    logic                  busy;
    logic                  done;
    logic [2:0]            lb_count;
    logic                  spr_ovf;

    sprite_line_sched_if bus ();

    sprite_line_sched #(.NUM_SPR(NSPR), .MAX_PER_LINE(MAXL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .next_row   (next_row),
        .flip_bit   (flip_bit),
        .spr_y      (spr_y),
        .spr_num    (spr_num),
        .spr_yflip  (spr_yflip),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .lb_count   (lb_count),
        .spr_ovf    (spr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM model: address-dependent pattern, one cycle latency
    function automatic logic [7:0] rom_fn(input int a);
        int t;
        t = (a * 37 + 11) % 4096;
        return 8'((t / 16) ^ (a % 256));
    endfunction

    always @(posedge clk) bus.rom_data <= rom_fn(int'(bus.rom_addr));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Line description used by the model
    int m_row, m_flip;
    int m_y [NSPR];
    int m_num [NSPR];
    int m_yf [NSPR];

    task automatic apply_attrs();
        next_row = 9'(m_row);
        flip_bit = 1'(m_flip);
        for (int i = 0; i < NSPR; i++) begin
            spr_y[i]     = 8'(m_y[i]);
            spr_num[i]   = 6'(m_num[i]);
            spr_yflip[i] = 1'(m_yf[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
        check_eq({tag, "_lb_we"},    32'(bus.lb_we), 0);
        check_eq({tag, "_lb_data"},  32'(bus.lb_data), 0);
        check_eq({tag, "_busy"},     32'(busy), 0);
        check_eq({tag, "_done"},     32'(done), 0);
        check_eq({tag, "_lb_count"}, 32'(lb_count), 0);
        check_eq({tag, "_spr_ovf"},  32'(spr_ovf), 0);
    endtask

    // Runs one line from the current negedge. abort_k>0 stops at that cycle
    // (leaving the line in progress); scramble rewrites already-evaluated
    // sprite attributes during EVAL.
    task automatic run_line(input int abort_k, input bit scramble);
        int n, ovf, d, done_k, j, s, b, addr;
        int e_spr [MAXL];
        int e_num [MAXL];
        int e_row [MAXL];
        n = 0;
        ovf = 0;
        for (int i = 0; i < NSPR; i++) begin
            d = ((m_row % 256) - m_y[i] + 256) % 256;
            if (m_row >= 16 && m_row <= 271 && d < 16) begin
                if (n < MAXL) begin
                    e_spr[n] = i;
                    e_num[n] = m_num[i];
                    e_row[n] = ((m_yf[i] ^ m_flip) != 0) ? 15 - d : d;
                    n++;
                end else begin
                    ovf = 1;
                end
            end
        end
        done_k = (n > 0) ? NSPR + 2 + 4 * n : NSPR + 1;

        apply_attrs();
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        for (int k = 1; k <= done_k + 1; k++) begin
            if (abort_k > 0 && k == abort_k) return;
            check_eq("busy", 32'(busy), 32'(k < done_k));
            check_eq("done", 32'(done), 32'(k == done_k));
            j = k - (NSPR + 1);
            if (j >= 0 && j < 4 * n) begin
                s = j / 4;
                b = j % 4;
                check_eq("rom_addr", 32'(bus.rom_addr), 32'(e_num[s] * 64 + e_row[s] * 4 + b));
            end
            j = k - (NSPR + 2);
            if (j >= 0 && j < 4 * n) begin
                s = j / 4;
                b = j % 4;
                addr = e_num[s] * 64 + e_row[s] * 4 + b;
                check_eq("lb_we",     32'(bus.lb_we), 1);
                check_eq("lb_slot",   32'(bus.lb_slot), 32'(s));
                check_eq("lb_byte",   32'(bus.lb_byte), 32'(b));
                check_eq("lb_sprite", 32'(bus.lb_sprite), 32'(e_spr[s]));
                check_eq("lb_data",   32'(bus.lb_data), 32'(rom_fn(addr)));
            end else begin
                check_eq("lb_we_idle", 32'(bus.lb_we), 0);
            end
            if (k >= done_k) begin
                check_eq("lb_count", 32'(lb_count), 32'(n));
`ifdef SPRITE_OVF_FLAG_EN
                check_eq("spr_ovf", 32'(spr_ovf), 32'(ovf));
`else
                check_eq("spr_ovf", 32'(spr_ovf), 0);
`endif
            end
            if (scramble && k >= 2 && k - 2 < NSPR) begin
                spr_y[k-2]     = 8'($urandom);
                spr_num[k-2]   = 6'($urandom);
                spr_yflip[k-2] = 1'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic set_line(input int row, input int flip, input int ydef);
        m_row = row;
        m_flip = flip;
        for (int i = 0; i < NSPR; i++) begin
            m_y[i]   = ydef;
            m_num[i] = (i * 7 + 3) % 64;
            m_yf[i]  = 0;
        end
    endtask

    task automatic rand_line();
        m_row  = $urandom_range(0, 300);
        m_flip = $urandom_range(0, 1);
        for (int i = 0; i < NSPR; i++) begin
            if ($urandom_range(0, 1) == 1) m_y[i] = ((m_row % 256) - $urandom_range(0, 17) + 256) % 256;
            else m_y[i] = $urandom_range(0, 255);
            m_num[i] = $urandom_range(0, 63);
            m_yf[i]  = $urandom_range(0, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        line_start = 1'b0;
        set_line(0, 0, 0);
        apply_attrs();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single hit, row offset 10
        set_line(100, 0, 0);
        m_y[2] = 90;
        m_num[2] = 42;
        run_line(0, 0);
        // Sprite flip cancelled by global flip, then global flip alone
        m_yf[2] = 1;
        m_flip = 1;
        run_line(0, 0);
        m_yf[2] = 0;
        run_line(0, 0);

        // Five hits: four kept, the fifth dropped
        set_line(50, 0, 200);
        for (int i = 0; i < 5; i++) m_y[i] = 50 - i;
        run_line(0, 0);

        // Wrap and row-range boundaries
        set_line(5, 0, 100);   m_y[0] = 250; run_line(0, 0);
        set_line(20, 0, 100);  m_y[0] = 250; run_line(0, 0);
        set_line(20, 0, 100);  m_y[0] = 10;  run_line(0, 0);
        set_line(271, 0, 100); m_y[0] = 0;   run_line(0, 0);
        set_line(272, 0, 100); m_y[0] = 5;   run_line(0, 0);
        set_line(16, 0, 100);  m_y[0] = 16;  run_line(0, 0);
        set_line(15, 0, 100);  m_y[0] = 10;  run_line(0, 0);

        // Restart mid-FETCH, then a fresh line
        set_line(50, 0, 200);
        for (int i = 0; i < 4; i++) m_y[i] = 45;
        run_line(NSPR + 6, 0);
        set_line(100, 1, 0);
        m_y[5] = 95;
        m_y[6] = 88;
        m_yf[6] = 1;
        run_line(0, 0);

        // Reset mid-FETCH
        set_line(50, 0, 200);
        for (int i = 0; i < 4; i++) m_y[i] = 40;
        run_line(NSPR + 7, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("post_rst");
        set_line(200, 0, 195);
        run_line(0, 0);

        // Randomized lines, half with attributes rewritten after evaluation
        for (int r = 0; r < 60; r++) begin
            rand_line();
            run_line(0, r[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
